// File: rtl/uart_boot_loader_p.sv
// Serial boot loader: receives an 8N1 image, packs it little-endian into RAM words, and verifies a mod-256 checksum (ACK/NAK).
// After a good load it releases boot, and a scan request dumps the RAM contents back out on tx.
module uart_boot_loader_p #(
    parameter int CLK_PER_BIT = 868,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              rx,
    output logic              tx,
    input  logic              scan_memory,
    output logic              boot,
    output logic              err,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int WB    = DATA_W / 8;
    localparam int BC_W  = (WB > 1) ? $clog2(WB) : 1;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [BC_W-1:0]   LAST_BC  = BC_W'(WB - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [2:0] {
        M_LOAD, M_CHECK, M_DONE, M_SCAN_RD, M_SCAN_LAT, M_SCAN_TX, M_SCAN_END
    } m_st_t;

    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic             sc_s1_q, sc_s2_q, sc_s3_q;
    rx_st_t           rx_st_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_sh_q;
    logic             rx_stb, rx_ok, rx_ferr;

    logic             tx_q, tx_busy_q;
    logic [9:0]       tx_frame_q;
    logic [3:0]       tx_bit_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic             tx_end, tx_free, tx_load, ack_load, scan_load;
    logic [7:0]       tx_byte_d, scan_byte;

    m_st_t             st_q;
    logic [ADDR_W-1:0] idx_q;
    logic [BC_W-1:0]   bc_q, sb_q;
    logic [7:0]        csum_q, ack_byte_q;
    logic [DATA_W-1:0] word_q, word_d, scan_q;
    logic              ack_pend_q, boot_q, err_q;
    logic              ram_en_q, ram_rw_q;
    logic [ADDR_W-1:0] ram_adr_q;
    logic [DATA_W-1:0] ram_in_q;

    assign rx_stb  = ce && (rx_st_q == RX_STOP) && (rx_cnt_q == LAST_CNT);
    assign rx_ok   = rx_stb && rx_s2_q;
    assign rx_ferr = rx_stb && !rx_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_s3_q  <= 1'b1;
            sc_s1_q  <= 1'b0;
            sc_s2_q  <= 1'b0;
            sc_s3_q  <= 1'b0;
            rx_st_q  <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
        end else if (ce) begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            sc_s1_q <= scan_memory;
            sc_s2_q <= sc_s1_q;
            sc_s3_q <= sc_s2_q;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // A line already high again at mid start bit was a glitch.
                    if (rx_cnt_q == HALF_CNT) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == LAST_CNT) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == LAST_CNT) rx_st_q <= RX_IDLE;
                    else rx_cnt_q <= rx_cnt_q + 1'b1;
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    assign tx_end  = tx_busy_q && (tx_cnt_q == LAST_CNT) && (tx_bit_q == 4'd9);
    assign tx_free = !tx_busy_q || tx_end;

    // A frame may be loaded in the last stop-bit cycle, giving gap-free bytes.
    always_comb begin
        word_d    = word_q;
        scan_byte = 8'h00;
        for (int k = 0; k < WB; k++) begin
            if (bc_q == BC_W'(k)) word_d[8*k +: 8] = rx_sh_q;
            if (sb_q == BC_W'(k)) scan_byte = scan_q[8*k +: 8];
        end
        ack_load  = ce && ack_pend_q && tx_free;
        scan_load = ce && !ack_pend_q && (st_q == M_SCAN_TX) && tx_free;
        tx_load   = ack_load || scan_load;
        tx_byte_d = ack_pend_q ? ack_byte_q : scan_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_frame_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else if (tx_load) begin
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_frame_q <= {1'b1, tx_byte_d, 1'b0};
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else if (ce && tx_busy_q) begin
            if (tx_cnt_q == LAST_CNT) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_bit_q   <= tx_bit_q + 1'b1;
                    tx_q       <= tx_frame_q[1];
                    tx_frame_q <= {1'b1, tx_frame_q[9:1]};
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= M_LOAD;
            idx_q      <= '0;
            bc_q       <= '0;
            sb_q       <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            scan_q     <= '0;
            ack_pend_q <= 1'b0;
            ack_byte_q <= '0;
            boot_q     <= 1'b1;
            err_q      <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_rw_q   <= 1'b0;
            ram_adr_q  <= '0;
            ram_in_q   <= '0;
        end else if (ce) begin
            ram_en_q <= 1'b0;
            if (ack_load) ack_pend_q <= 1'b0;
            if (rx_ferr) err_q <= 1'b1;
            case (st_q)
                M_LOAD: begin
                    if (rx_ok) begin
                        csum_q <= csum_q + rx_sh_q;
                        if (bc_q == LAST_BC) begin
                            bc_q      <= '0;
                            word_q    <= '0;
                            ram_en_q  <= 1'b1;
                            ram_rw_q  <= 1'b1;
                            ram_adr_q <= idx_q;
                            ram_in_q  <= word_d;
                            if (idx_q == LAST_IDX) st_q <= M_CHECK;
                            else idx_q <= idx_q + 1'b1;
                        end else begin
                            bc_q   <= bc_q + 1'b1;
                            word_q <= word_d;
                        end
                    end
                end
                M_CHECK: begin
                    if (rx_ok) begin
                        ack_pend_q <= 1'b1;
                        if (rx_sh_q == csum_q) begin
                            ack_byte_q <= 8'h06;
                            boot_q     <= 1'b0;
                            st_q       <= M_DONE;
                        end else begin
                            ack_byte_q <= 8'h15;
                            err_q      <= 1'b1;
                            idx_q      <= '0;
                            csum_q     <= '0;
                            bc_q       <= '0;
                            st_q       <= M_LOAD;
                        end
                    end
                end
                M_DONE: begin
                    if (sc_s2_q && !sc_s3_q) begin
                        ram_en_q  <= 1'b1;
                        ram_rw_q  <= 1'b0;
                        ram_adr_q <= '0;
                        idx_q     <= '0;
                        st_q      <= M_SCAN_RD;
                    end
                end
                M_SCAN_RD: st_q <= M_SCAN_LAT;
                M_SCAN_LAT: begin
                    scan_q <= ram_out;
                    sb_q   <= '0;
                    st_q   <= M_SCAN_TX;
                end
                M_SCAN_TX: begin
                    if (scan_load) begin
                        if (sb_q == LAST_BC) begin
                            sb_q <= '0;
                            if (idx_q == LAST_IDX) begin
                                st_q <= M_SCAN_END;
                            end else begin
                                idx_q     <= idx_q + 1'b1;
                                ram_en_q  <= 1'b1;
                                ram_rw_q  <= 1'b0;
                                ram_adr_q <= idx_q + 1'b1;
                                st_q      <= M_SCAN_RD;
                            end
                        end else begin
                            sb_q <= sb_q + 1'b1;
                        end
                    end
                end
                M_SCAN_END: begin
                    if (!tx_busy_q) begin
                        ram_adr_q <= '0;
                        idx_q     <= '0;
                        st_q      <= M_DONE;
                    end
                end
                default: st_q <= M_LOAD;
            endcase
        end
    end

    assign tx         = tx_q;
    assign boot       = boot_q;
    assign err        = err_q;
    assign ram_enable = ram_en_q;
    assign ram_rw     = ram_rw_q;
    assign ram_adr    = ram_adr_q;
    assign ram_in     = ram_in_q;

endmodule

// File: tb/tb_uart_boot_loader_p.sv
// Bench for uart_boot_loader_p: UART driver/decoder, RAM model and an image-level reference model.
module tb_uart_boot_loader_p;
    localparam int CPB = 16;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int DEP = 4;
    localparam int WB  = DW / 8;
    localparam int NB  = WB * DEP;

    logic          clk = 1'b0;
    logic          rst = 1'b1, ce = 1'b1, rx = 1'b1, scan_memory = 1'b0;
    logic          tx, boot, err, ram_enable, ram_rw;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out = '0;

    uart_boot_loader_p #(.CLK_PER_BIT(CPB), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rx(rx), .tx(tx), .scan_memory(scan_memory),
        .boot(boot), .err(err), .ram_enable(ram_enable), .ram_rw(ram_rw),
        .ram_adr(ram_adr), .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, multi = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [7:0]    txq [$];
    int            txt [$];
    logic [AW-1:0] wadr [$];
    logic [DW-1:0] wdat [$];
    logic [AW-1:0] radr [$];
    logic          prev_en = 1'b0;
    logic          pause_viol = 1'b0;
    logic [7:0]    img [0:NB-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else ram_out <= mem[ram_adr];
        end
    end

    always @(negedge clk) begin
        if (ram_enable === 1'b1) begin
            if (ram_rw) begin
                wadr.push_back(ram_adr);
                wdat.push_back(ram_in);
            end else begin
                radr.push_back(ram_adr);
            end
            if (prev_en) multi++;
        end
        prev_en = (ram_enable === 1'b1);
    end

    initial begin : txmon
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                txq.push_back(b);
                txt.push_back(t0);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [DW-1:0] exp_word(input int k);
        logic [DW-1:0] w;
        for (int b = 0; b < WB; b++) w[8*b +: 8] = img[WB*k + b];
        return w;
    endfunction

    function automatic logic [7:0] exp_sum();
        int s = 0;
        for (int i = 0; i < NB; i++) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    task automatic clear_mon();
        txq.delete(); txt.delete(); wadr.delete(); wdat.delete(); radr.delete();
        multi = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1; rx = 1'b1; scan_memory = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_b, input int pause_bit);
        logic t0, b0, e0;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == pause_bit) begin
                ce = 1'b0;
                t0 = tx; b0 = boot; e0 = ram_enable;
                repeat (200) begin
                    @(negedge clk);
                    if (tx !== t0 || boot !== b0 || ram_enable !== e0) pause_viol = 1'b1;
                end
                ce = 1'b1;
            end
            repeat (CPB) @(negedge clk);
        end
        rx = stop_b;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_image(input logic [7:0] cs, input int pause_byte);
        for (int i = 0; i < NB; i++) send_byte(img[i], 1'b1, (i == pause_byte) ? 4 : -1);
        send_byte(cs, 1'b1, -1);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (txq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic fixed_image();
        for (int i = 0; i < NB; i++) img[i] = 8'(8'h11 * (i + 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (boot !== 1'b1) begin failures++; $display("FAIL reset_boot got %b want 1", boot); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (ram_enable !== 1'b0) begin failures++; $display("FAIL reset_en got %b want 0", ram_enable); end
        checks++; if (ram_adr !== '0) begin failures++; $display("FAIL reset_adr got %h want 0", ram_adr); end
        checks++; if (ram_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got %b want 0", ram_rw); end
        checks++; if (ram_in !== '0) begin failures++; $display("FAIL reset_in got %h want 0", ram_in); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_load();
        bit ok;
        do_reset(); clear_mon(); fixed_image();
        checks++; if (exp_sum() !== 8'h64) begin failures++; $display("FAIL good_sum model got %h want 64", exp_sum()); end
        send_image(8'h64, -1);
        wait_tx(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL good_ack_timeout got 0 want 1 bytes"); end
        checks++; if (wadr.size() !== DEP) begin failures++; $display("FAIL good_nwr got %0d want %0d", wadr.size(), DEP); end
        for (int k = 0; k < DEP && k < wadr.size(); k++) begin
            checks++; if (wadr[k] !== AW'(k) || wdat[k] !== exp_word(k)) begin
                failures++; $display("FAIL good_wr%0d got %h@%h want %h@%h", k, wdat[k], wadr[k], exp_word(k), AW'(k)); end
        end
        checks++; if (ok && txq[0] !== 8'h06) begin failures++; $display("FAIL good_ack got %h want 06", txq[0]); end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL good_boot got %b want 0", boot); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL good_err got %b want 0", err); end
        checks++; if (multi !== 0) begin failures++; $display("FAIL good_strobe_len got %0d want 0", multi); end
    endtask

    task automatic test_scan();
        bit ok;
        repeat (200) @(negedge clk);
        clear_mon();
        scan_memory = 1'b1;
        wait_tx(NB, ok);
        checks++; if (!ok) begin failures++; $display("FAIL scan_timeout got %0d want %0d bytes", txq.size(), NB); end
        repeat (250) @(negedge clk);
        checks++; if (radr.size() !== DEP) begin failures++; $display("FAIL scan_nrd got %0d want %0d", radr.size(), DEP); end
        for (int k = 0; k < radr.size(); k++) begin
            checks++; if (radr[k] !== AW'(k)) begin failures++; $display("FAIL scan_rd%0d got %h want %h", k, radr[k], AW'(k)); end
        end
        for (int i = 0; i < NB && i < txq.size(); i++) begin
            checks++; if (txq[i] !== img[i]) begin failures++; $display("FAIL scan_byte%0d got %h want %h", i, txq[i], img[i]); end
        end
        for (int i = 1; i < txt.size(); i++) begin
            if (i % WB != 0) begin
                checks++; if (txt[i] - txt[i-1] !== 10*CPB) begin
                    failures++; $display("FAIL scan_gap%0d got %0d want %0d", i, txt[i] - txt[i-1], 10*CPB); end
            end
        end
        checks++; if (txq.size() !== NB) begin failures++; $display("FAIL scan_count got %0d want %0d", txq.size(), NB); end
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL scan_idle got %b want 1", tx); end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL scan_boot got %b want 0", boot); end
        checks++; if (ram_adr !== '0) begin failures++; $display("FAIL scan_adr got %h want 0", ram_adr); end
        scan_memory = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bad_checksum();
        bit ok;
        do_reset(); clear_mon(); fixed_image();
        send_image(8'h65, -1);
        wait_tx(1, ok);
        checks++; if (!ok || txq[0] !== 8'h15) begin failures++; $display("FAIL bad_nak got %h want 15", ok ? txq[0] : 8'hxx); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_err got %b want 1", err); end
        checks++; if (boot !== 1'b1) begin failures++; $display("FAIL bad_boot got %b want 1", boot); end
        repeat (200) @(negedge clk);
        clear_mon();
        send_image(8'h64, -1);
        wait_tx(1, ok);
        checks++; if (wadr.size() !== DEP) begin failures++; $display("FAIL bad_rewr got %0d want %0d", wadr.size(), DEP); end
        for (int k = 0; k < wadr.size(); k++) begin
            checks++; if (wadr[k] !== AW'(k) || wdat[k] !== exp_word(k)) begin
                failures++; $display("FAIL bad_rewr%0d got %h@%h want %h@%h", k, wdat[k], wadr[k], exp_word(k), AW'(k)); end
        end
        checks++; if (!ok || txq[0] !== 8'h06) begin failures++; $display("FAIL bad_reack got %h want 06", ok ? txq[0] : 8'hxx); end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL bad_reboot got %b want 0", boot); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_sticky got %b want 1", err); end
    endtask

    task automatic test_framing();
        bit ok;
        do_reset(); clear_mon(); fixed_image();
        send_byte(8'h11, 1'b0, -1);
        repeat (20) @(negedge clk);
        checks++; if (wadr.size() !== 0) begin failures++; $display("FAIL frame_nowr got %0d want 0", wadr.size()); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL frame_err got %b want 1", err); end
        send_image(8'h64, -1);
        wait_tx(1, ok);
        checks++; if (!ok || txq[0] !== 8'h06) begin failures++; $display("FAIL frame_ack got %h want 06", ok ? txq[0] : 8'hxx); end
        checks++; if (wadr.size() < 1 || wdat[0] !== exp_word(0)) begin failures++; $display("FAIL frame_wr0 got %h want %h", wdat[0], exp_word(0)); end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL frame_boot got %b want 0", boot); end
    endtask

    task automatic test_glitch();
        bit ok;
        do_reset(); clear_mon(); fixed_image();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_image(8'h64, -1);
        wait_tx(1, ok);
        checks++; if (!ok || txq[0] !== 8'h06) begin failures++; $display("FAIL glitch_ack got %h want 06", ok ? txq[0] : 8'hxx); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL glitch_err got %b want 0", err); end
        checks++; if (wadr.size() !== DEP) begin failures++; $display("FAIL glitch_nwr got %0d want %0d", wadr.size(), DEP); end
    endtask

    task automatic test_ce_pause();
        bit ok;
        do_reset(); clear_mon();
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
        pause_viol = 1'b0;
        send_image(exp_sum(), 3);
        wait_tx(1, ok);
        checks++; if (pause_viol !== 1'b0) begin failures++; $display("FAIL ce_frozen got %b want 0", pause_viol); end
        checks++; if (!ok || txq[0] !== 8'h06) begin failures++; $display("FAIL ce_ack got %h want 06", ok ? txq[0] : 8'hxx); end
        checks++; if (wadr.size() !== DEP) begin failures++; $display("FAIL ce_nwr got %0d want %0d", wadr.size(), DEP); end
        for (int k = 0; k < wadr.size(); k++) begin
            checks++; if (wdat[k] !== exp_word(k)) begin failures++; $display("FAIL ce_wr%0d got %h want %h", k, wdat[k], exp_word(k)); end
        end
        checks++; if (boot !== 1'b0) begin failures++; $display("FAIL ce_boot got %b want 0", boot); end
    endtask

    task automatic test_reset_scan();
        bit ok;
        repeat (200) @(negedge clk);
        clear_mon();
        scan_memory = 1'b1;
        wait_tx(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rscan_timeout got %0d want 2 bytes", txq.size()); end
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rscan_tx got %b want 1", tx); end
        checks++; if (boot !== 1'b1) begin failures++; $display("FAIL rscan_boot got %b want 1", boot); end
        rst = 1'b0; scan_memory = 1'b0;
        repeat (300) @(negedge clk);
        clear_mon();
        fixed_image();
        send_image(8'h64, -1);
        wait_tx(1, ok);
        checks++; if (!ok || txq[0] !== 8'h06) begin failures++; $display("FAIL rscan_reload got %h want 06", ok ? txq[0] : 8'hxx); end
        checks++; if (wadr.size() < 1 || wadr[0] !== '0) begin failures++; $display("FAIL rscan_adr0 got %h want 0", wadr[0]); end
    endtask

    task automatic test_random();
        bit ok, good;
        logic [7:0] cs, want_ack;
        for (int it = 0; it < 4; it++) begin
            do_reset(); clear_mon();
            for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
            good = bit'($urandom_range(0, 1));
            cs = good ? exp_sum() : 8'(exp_sum() + 8'($urandom_range(1, 255)));
            want_ack = good ? 8'h06 : 8'h15;
            send_image(cs, -1);
            wait_tx(1, ok);
            checks++; if (!ok || txq[0] !== want_ack) begin failures++; $display("FAIL rnd%0d_ack got %h want %h", it, ok ? txq[0] : 8'hxx, want_ack); end
            checks++; if (wadr.size() !== DEP) begin failures++; $display("FAIL rnd%0d_nwr got %0d want %0d", it, wadr.size(), DEP); end
            for (int k = 0; k < wadr.size(); k++) begin
                checks++; if (wadr[k] !== AW'(k) || wdat[k] !== exp_word(k)) begin
                    failures++; $display("FAIL rnd%0d_wr%0d got %h@%h want %h", it, k, wdat[k], wadr[k], exp_word(k)); end
            end
            checks++; if (boot !== !good) begin failures++; $display("FAIL rnd%0d_boot got %b want %b", it, boot, !good); end
            checks++; if (err !== !good) begin failures++; $display("FAIL rnd%0d_err got %b want %b", it, err, !good); end
            if (good) begin
                repeat (200) @(negedge clk);
                scan_memory = 1'b1;
                wait_tx(1 + NB, ok);
                checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_scan got %0d want %0d bytes", it, txq.size(), 1 + NB); end
                for (int i = 0; i < NB && i + 1 < txq.size(); i++) begin
                    checks++; if (txq[i+1] !== img[i]) begin failures++; $display("FAIL rnd%0d_sb%0d got %h want %h", it, i, txq[i+1], img[i]); end
                end
                scan_memory = 1'b0;
                repeat (200) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_scan();
        test_bad_checksum();
        test_framing();
        test_glitch();
        test_ce_pause();
        test_reset_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader_p.md
Name: uart_boot_loader_p

Overview:
- Parametrised successor to the fixed single-UART boot loader.
- Receives a program image over an 8N1 UART and packs bytes into DATA_W-bit words, little-endian. Writes the words to an external synchronous RAM at addresses 0..DEPTH-1.
- Checks a trailing mod-256 checksum and replies with ACK or NAK, then releases the core by dropping boot.
- New versus the previous generation: configurable word width, depth and baud; checksum with ACK/NAK; sticky error flag; scan mode that dumps RAM contents back over tx.

Parameters:
- CLK_PER_BIT, 868, clk cycles per UART bit (at least 4).
- DATA_W, 16, RAM word width; multiple of 8, range 8..32; WORD_BYTES = DATA_W/8.
- ADDR_W, 8, RAM address width.
- DEPTH, 256, number of words loaded and scanned; 1 ≤ DEPTH ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when 0 all state including UART counters is frozen
- rx  in  1  UART receive, idle high, asynchronous, 2-flop synchronised internally
- tx  out  1  UART transmit, idle high
- scan_memory  in  1  scan request level, 2-flop synchronised, rising edge detected
- boot  out  1  1 = core held, load in progress; 0 = image valid
- err  out  1  sticky error flag
- ram_enable  out  1  RAM access strobe, one cycle per access
- ram_rw  out  1  1 = write, 0 = read; valid when ram_enable=1
- ram_adr  out  ADDR_W  RAM word address
- ram_in  out  DATA_W  write data into RAM
- ram_out  in  DATA_W  read data from RAM, valid exactly 1 cycle after a read strobe

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: tx=1, boot=1, err=0, ram_enable=0, ram_rw=0, ram_adr=0, ram_in=0. FSM enters LOAD with word index 0, byte count 0, checksum 0.
- rst overrides ce. Reset mid-load or mid-scan aborts immediately: tx=1 on the next cycle and any partial word is discarded.
- UART RX:
  - A falling edge on synchronised rx starts reception.
  - Start bit re-sampled at CLK_PER_BIT/2; a high sample there is a glitch and reception is abandoned.
  - Data bits sampled mid-bit, LSB first.
  - A stop bit sampled 0 is a framing error: set err, discard the byte.
- UART TX: start bit, 8 data bits LSB first, stop bit; each bit lasts CLK_PER_BIT cycles.
- LOAD (boot=1):
  - Each valid byte is added to the 8-bit checksum (wraps mod 256) and shifted into bits [8k+7:8k] of the word assembler, where k is the byte position 0..WORD_BYTES-1.
  - After WORD_BYTES bytes: one cycle with ram_enable=1, ram_rw=1, ram_adr=index, ram_in=word; then index+1.
  - Write occurs 1 cycle after the last byte's stop-bit sample.
  - After write index DEPTH-1, go to CHECK. The index never wraps silently.
- CHECK:
  - Next valid byte compared with the accumulated checksum.
  - Match: transmit 0x06; boot goes to 0 in the cycle the comparison resolves; go to DONE.
  - Mismatch: transmit 0x15, set err, clear index/checksum/byte count, return to LOAD (boot stays 1).
- DONE (boot=0):
  - Further rx bytes are ignored.
  - A scan_memory rising edge enters SCAN.
  - scan_memory is ignored in LOAD and CHECK, and while SCAN is active.
- SCAN, for addr 0..DEPTH-1:
  - One read strobe (ram_enable=1, ram_rw=0).
  - Latch ram_out on the next cycle.
  - Transmit WORD_BYTES bytes, LSB first, back to back: next start bit immediately after the previous stop bit, with no idle gap.
  - Then next address; after DEPTH-1 return to DONE with ram_adr=0.
- Simultaneous events:
  - An rx byte completing while tx is busy in LOAD/CHECK is still processed. The RX path is independent; only ACK/NAK uses tx there.
  - A new image is only accepted after reset.
- err clears only on reset.

Test Plan:
- Reset: assert rst 2 cycles with ce=1 → tx=1, boot=1, err=0, ram_enable=0, ram_adr=0.
- Good load (CLK_PER_BIT=16, DATA_W=16, DEPTH=4): send 11 22 33 44 55 66 77 88, then checksum 0x64 → four writes:
  - adr0=0x2211, adr1=0x4433, adr2=0x6655, adr3=0x8877;
  - each write is a single cycle with ram_rw=1;
  - tx sends 0x06, boot falls to 0, err=0.
- Bad checksum: same 8 bytes, then 0x65 → tx sends 0x15, err=1, boot=1. A repeated correct image then writes again starting at adr0 and ends with boot=0.
- Framing error: byte 0x11 sent with stop bit 0 → no write, err=1, checksum unaffected. The following correct image loads normally with checksum 0x64.
- Scan: after good load, with RAM model returning the stored words, raise scan_memory → 4 read strobes at adr 0..3; tx bytes 11 22 33 44 55 66 77 88 in order, then idle high; boot stays 0.
- ce and reset: hold ce=0 for 200 cycles in the middle of a word (bench also freezes rx) → no state change, load completes correctly afterwards. Assert rst during SCAN byte 3 → next cycle tx=1, boot=1, state LOAD.
